cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle sequencer for the WISC datapath, replacing the single-cycle assumption.
- Steps each instruction through FETCH, DECODE, optional MEM, then WB.
- Handshakes with the instruction and data memories (req/done), gates the control decoder's write and memory enables, and halts on HALT or on a decoder exception.
- Sits between the control decoder, the PC/IR registers, the register file write port and both memories.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for done before the error trap (legal range 2..255).
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_op  in  5  opcode field of latched IR (00000 = HALT, 00001 = NOP)
RegWriteEn  in  1  decoder register-write request
MemEn  in  1  decoder memory-access request
MemWr  in  1  decoder store(1)/load(0)
Exception  in  1  decoder illegal-opcode flag
imem_done  in  1  instruction memory read complete (1-cycle pulse)
dmem_done  in  1  data memory access complete (1-cycle pulse)
imem_req  out  1  instruction fetch request
ir_we  out  1  latch fetched instruction into IR
dmem_req  out  1  data memory request
dmem_wr  out  1  data memory write strobe
pc_we  out  1  commit next PC
rf_we  out  1  gated register-file write enable
halted  out  1  sticky HALT indication
err  out  1  sticky error trap
err_code  out  2  00 none, 01 decoder exception, 10 memory timeout
state  out  3  encoded FSM state, for debug
retire_cnt  out  CNT_W  instructions committed since reset

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=BOOT.
  - retire_cnt=0, wait counter=0, err_code=00.
  - All outputs 0.
  - Reset asserted mid-operation aborts any outstanding request immediately. Late done pulses after reset are ignored.
- State encoding: BOOT=000, FETCH=001, DECODE=010, MEM=011, WB=100, HALT=101, ERR=110.
- BOOT: outputs 0. Next cycle goes to FETCH.
- FETCH:
  - imem_req=1 every cycle.
  - On imem_done: ir_we=1 in the same cycle, then DECODE. Wait counter clears.
  - Otherwise the wait counter increments. When the counter reaches MEM_TIMEOUT with no done: go to ERR with err_code=10.
- DECODE: one cycle, all strobes 0. Priority order:
  1. instr_op==00000 -> HALT
  2. Exception=1 -> ERR, err_code=01
  3. MemEn=1 -> MEM
  4. otherwise -> WB
- MEM:
  - dmem_req=1 and dmem_wr=MemWr, held stable until done.
  - On dmem_done: go to WB.
  - Same timeout rule as FETCH (counter cleared on entry).
- WB: one cycle.
  - pc_we=1.
  - rf_we = RegWriteEn AND NOT (MemEn AND MemWr): stores never write the register file.
  - retire_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - Next state FETCH.
- NOP (00001) takes the WB path with RegWriteEn as supplied. Minimum latency is 3 cycles (FETCH with immediate done, DECODE, WB), or 4 cycles with MEM.
- HALT: halted=1, all strobes 0, terminal until reset. The HALT instruction does not increment retire_cnt and does not write the PC.
- ERR: err=1, err_code held, all strobes 0, terminal until reset.
- Strobes:
  - Strobe outputs (imem_req, ir_we, dmem_req, dmem_wr, pc_we, rf_we) are combinational from state and current inputs.
  - halted, err, err_code, retire_cnt are registered.
  - A done pulse received in a state not awaiting it is ignored.
- Decoder inputs only matter in DECODE, MEM and WB, and the datapath holds IR stable from ir_we until the next FETCH. X on decoder outputs in other states must not propagate to strobes: every strobe is forced to 0 outside its owning state.

Test Plan:
1. Release reset, ALU op (instr_op=01000, RegWriteEn=1, MemEn=0), imem_done 2 cycles after FETCH entry -> imem_req high 3 cycles, ir_we in 3rd; pc_we=1 and rf_we=1 two cycles later; retire_cnt=1.
2. Load (10001, MemEn=1, MemWr=0, RegWriteEn=1), dmem_done on 4th MEM cycle -> dmem_req=1, dmem_wr=0 for 4 cycles; WB rf_we=1; retire_cnt +1.
3. Store (10000, MemEn=1, MemWr=1) -> dmem_wr=1 throughout MEM; WB rf_we=0, pc_we=1.
4. HALT (instr_op=00000) after 2 retired instructions -> state=101, halted=1 forever, no pc_we, retire_cnt stays 2; late imem_done pulses ignored.
5. Exception=1 in DECODE -> err=1, err_code=01, state=110; then imem_done never -> after reset, FETCH waits MEM_TIMEOUT=16 cycles -> err_code=10.
6. Assert rst_n=0 during MEM with dmem_req high -> dmem_req drops in same cycle (async), retire_cnt=0, state=000; dmem_done arriving after release has no effect.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
//   Groups the signals between the multi-cycle sequencer and its
//   surroundings: the control decoder, both memories, the PC/IR registers
//   and the register-file write port.
//   master : the sequencer side (consumes decoder fields and done pulses,
//            drives strobes and status)
//   slave  : the datapath/memory side (the reverse directions)
// Signals:
//   instr_op[4:0], RegWriteEn, MemEn, MemWr, Exception : decoder fields
//   imem_done, dmem_done : 1-cycle completion pulses from the memories
//   imem_req, ir_we, dmem_req, dmem_wr, pc_we, rf_we   : strobes
//   halted, err, err_code[1:0], state[2:0], retire_cnt : status/debug
interface cpu_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       instr_op;
  logic             RegWriteEn;
  logic             MemEn;
  logic             MemWr;
  logic             Exception;
  logic             imem_done;
  logic             dmem_done;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_wr;
  logic             pc_we;
  logic             rf_we;
  logic             halted;
  logic             err;
  logic [1:0]       err_code;
  logic [2:0]       state;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    input  instr_op, RegWriteEn, MemEn, MemWr, Exception, imem_done, dmem_done,
    output imem_req, ir_we, dmem_req, dmem_wr, pc_we, rf_we,
           halted, err, err_code, state, retire_cnt
  );

  modport slave (
    output instr_op, RegWriteEn, MemEn, MemWr, Exception, imem_done, dmem_done,
    input  imem_req, ir_we, dmem_req, dmem_wr, pc_we, rf_we,
           halted, err, err_code, state, retire_cnt
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle sequencer for the WISC datapath. Each instruction walks
//   FETCH -> DECODE -> (MEM) -> WB. Memory requests wait for a done pulse
//   and trap to ERR if none arrives within MEM_TIMEOUT cycles. HALT and
//   decoder exceptions are terminal until reset.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cpu_sequencer_if.master (decoder inputs, memory handshakes,
//           gated strobes, sticky halted/err, err_code, state, retire_cnt)
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    BOOT   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    HALT   = 3'b101,
    ERR    = 3'b110
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_EXC     = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  // Last permitted waiting cycle: a cycle without done at this count traps.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       wait_cnt;
  logic             wait_expired;
  logic [CNT_W-1:0] retire_q;
  logic             halted_q;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic [1:0]       err_code_d;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Next-state and strobe decode. Every strobe defaults to 0 and is only
  // raised inside its owning state, so X on decoder fields elsewhere
  // cannot leak onto the datapath.
  always_comb begin
    state_d      = state_q;
    err_code_d   = CODE_NONE;
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_wr  = 1'b0;
    bus.pc_we    = 1'b0;
    bus.rf_we    = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_done) begin
          bus.ir_we = 1'b1;
          state_d   = DECODE;
        end else if (wait_expired) begin
          state_d    = ERR;
          err_code_d = CODE_TIMEOUT;
        end
      end
      DECODE: begin
        // HALT wins over an exception flag, which wins over memory access.
        if (bus.instr_op == 5'b00000) begin
          state_d = HALT;
        end else if (bus.Exception) begin
          state_d    = ERR;
          err_code_d = CODE_EXC;
        end else if (bus.MemEn) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_wr  = bus.MemWr;
        if (bus.dmem_done) begin
          state_d = WB;
        end else if (wait_expired) begin
          state_d    = ERR;
          err_code_d = CODE_TIMEOUT;
        end
      end
      WB: begin
        bus.pc_we = 1'b1;
        // Stores never write the register file.
        bus.rf_we = bus.RegWriteEn & ~(bus.MemEn & bus.MemWr);
        state_d   = FETCH;
      end
      HALT: state_d = HALT;
      ERR:  state_d = ERR;
      default: state_d = BOOT;
    endcase
  end

  // State, wait counter and registered status. The wait counter runs only
  // while a request is outstanding and is zero in every other state, so it
  // is already clear on entry to FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      wait_cnt   <= 8'd0;
      retire_q   <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= CODE_NONE;
    end else begin
      state_q <= state_d;
      if ((state_q == FETCH && !bus.imem_done) ||
          (state_q == MEM && !bus.dmem_done)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (state_q == WB) begin
        retire_q <= retire_q + CNT_W'(1);
      end
      if (state_d == HALT) begin
        halted_q <= 1'b1;
      end
      if (state_d == ERR && state_q != ERR) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_d;
      end
    end
  end

  assign bus.halted     = halted_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.state      = state_q;
  assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Self-checking bench for cpu_sequencer: a table of single-instruction
//   vectors, hand-written multi-cycle sequences (latency, halt, exception,
//   timeout, async reset) and randomized programs scored against a
//   program-level model (cycle and strobe totals from instruction latencies).
module tb_cpu_sequencer;

  localparam int TMO = 16;
  localparam int CW  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cpu_sequencer_if #(.CNT_W(CW)) bus ();

  cpu_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic       rwe;
    logic       men;
    logic       mwr;
    logic       exc;
    logic [2:0] exp_state;
    logic       exp_wr;
    logic       exp_rf;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mkVec(logic [4:0] op, logic rwe, logic men, logic mwr,
                                 logic exc, logic [2:0] st, logic wr, logic rf,
                                 logic [1:0] code);
    vec_t v;
    v.op = op; v.rwe = rwe; v.men = men; v.mwr = mwr; v.exc = exc;
    v.exp_state = st; v.exp_wr = wr; v.exp_rf = rf; v.exp_code = code;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic setFields(input logic [4:0] op, input logic rwe, input logic men,
                           input logic mwr, input logic exc);
    bus.instr_op = op; bus.RegWriteEn = rwe; bus.MemEn = men;
    bus.MemWr = mwr; bus.Exception = exc;
  endtask

  // Hold reset for two cycles; returns at the negedge where reset is
  // released, i.e. during the BOOT cycle.
  task automatic doReset;
    rst_n = 1'b0;
    setFields(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.imem_done = 1'b0;
    bus.dmem_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at the negedge of the first FETCH cycle; done on cycle lat.
  // Returns at the negedge of the DECODE cycle.
  task automatic fetchWith(input int lat, input string tag);
    for (int c = 1; c <= lat; c++) begin
      bus.imem_done = (c == lat);
      #1;
      checkOutput({tag, " imem_req"}, bus.imem_req, 1);
      checkOutput({tag, " ir_we"}, bus.ir_we, (c == lat) ? 1 : 0);
      @(negedge clk);
      bus.imem_done = 1'b0;
    end
  endtask

  // Called at the negedge of the first MEM cycle; returns at WB negedge.
  task automatic memWith(input int lat, input logic exp_wr, input string tag);
    for (int c = 1; c <= lat; c++) begin
      bus.dmem_done = (c == lat);
      #1;
      checkOutput({tag, " dmem_req"}, bus.dmem_req, 1);
      checkOutput({tag, " dmem_wr"}, bus.dmem_wr, exp_wr);
      @(negedge clk);
      bus.dmem_done = 1'b0;
    end
  endtask

  // One table vector: reset, immediate fetch, then check the DECODE
  // outcome and, where applicable, the MEM and WB strobes.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    doReset();
    @(negedge clk);
    setFields(v.op, v.rwe, v.men, v.mwr, v.exc);
    fetchWith(1, tag);
    #1;
    checkOutput({tag, " decode strobes"},
                {bus.pc_we, bus.rf_we, bus.dmem_req, bus.imem_req}, 0);
    @(negedge clk);
    #1;
    checkOutput({tag, " state after decode"}, bus.state, v.exp_state);
    if (v.exp_state == 3'd3) begin
      memWith(1, v.exp_wr, tag);
      #1;
    end
    if (v.exp_state == 3'd3 || v.exp_state == 3'd4) begin
      checkOutput({tag, " pc_we"}, bus.pc_we, 1);
      checkOutput({tag, " rf_we"}, bus.rf_we, v.exp_rf);
    end else if (v.exp_state == 3'd6) begin
      checkOutput({tag, " err"}, bus.err, 1);
      checkOutput({tag, " err_code"}, bus.err_code, v.exp_code);
    end else begin
      checkOutput({tag, " halted"}, bus.halted, 1);
      checkOutput({tag, " halt pc_we"}, bus.pc_we, 0);
    end
  endtask

  // Random program of n instructions plus a HALT. The model predicts
  // totals directly from per-instruction latencies and classes.
  task automatic runRandom(input int n, input int round);
    logic [4:0] r_op[40];
    logic       r_rwe[40], r_men[40], r_mwr[40];
    int         r_f[40], r_m[40];
    int exp_imem, exp_dreq, exp_dwr, exp_rf, exp_cyc;
    int c_imem, c_irwe, c_dreq, c_dwr, c_pc, c_rf, cyc;
    int cur, fcnt, mcnt, cls;
    logic loaded, finished;
    string tag;
    tag = $sformatf("rand%0d", round);
    exp_imem = 0; exp_dreq = 0; exp_dwr = 0; exp_rf = 0; exp_cyc = 0;
    for (int i = 0; i <= n; i++) begin
      cls = $urandom_range(3, 0);
      r_f[i] = $urandom_range(4, 1);
      r_m[i] = 0;
      r_rwe[i] = 1'($urandom);
      r_mwr[i] = 1'($urandom);
      r_men[i] = (cls >= 2);
      if (cls >= 2) begin
        r_m[i] = $urandom_range(4, 1);
        r_mwr[i] = (cls == 3);
        r_op[i] = (cls == 3) ? 5'b10000 : 5'b10001;
      end else begin
        r_op[i] = (cls == 1) ? 5'b00001 : 5'($urandom_range(31, 2));
      end
      if (i == n) begin
        r_op[i] = 5'b00000;
        r_m[i] = 0;
        exp_cyc += r_f[i] + 1;
      end else begin
        exp_cyc += r_f[i] + 1 + r_m[i] + 1;
        exp_dreq += r_m[i];
        if (r_men[i] && r_mwr[i]) exp_dwr += r_m[i];
        if (r_rwe[i] && !(r_men[i] && r_mwr[i])) exp_rf++;
      end
      exp_imem += r_f[i];
    end
    c_imem = 0; c_irwe = 0; c_dreq = 0; c_dwr = 0; c_pc = 0; c_rf = 0; cyc = 0;
    cur = 0; fcnt = 0; mcnt = 0; loaded = 1'b0; finished = 1'b0;
    doReset();
    @(negedge clk);
    for (int k = 0; k < 2000 && !finished; k++) begin
      if (loaded) begin
        setFields(r_op[cur], r_rwe[cur], r_men[cur], r_mwr[cur], 1'b0);
      end else begin
        setFields(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      bus.imem_done = 1'b0;
      bus.dmem_done = 1'b0;
      #1;
      if (bus.halted) begin
        finished = 1'b1;
      end else begin
        if (bus.imem_req) begin
          fcnt++;
          bus.imem_done = (fcnt == r_f[cur]);
        end else begin
          bus.imem_done = ($urandom_range(3, 0) == 0);
        end
        if (bus.dmem_req) begin
          mcnt++;
          bus.dmem_done = (mcnt == r_m[cur]);
        end else begin
          bus.dmem_done = ($urandom_range(3, 0) == 0);
        end
        #1;
        cyc++;
        c_imem += int'(bus.imem_req);
        c_irwe += int'(bus.ir_we);
        c_dreq += int'(bus.dmem_req);
        c_dwr  += int'(bus.dmem_wr);
        c_pc   += int'(bus.pc_we);
        c_rf   += int'(bus.rf_we);
        if (bus.ir_we) begin
          fcnt = 0;
          loaded = 1'b1;
        end
        if (bus.dmem_req && bus.dmem_done) mcnt = 0;
        if (bus.pc_we && cur < n) begin
          cur++;
          loaded = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.imem_done = 1'b0;
    bus.dmem_done = 1'b0;
    checkOutput({tag, " reached halt"}, finished, 1);
    checkOutput({tag, " cycles"}, cyc, exp_cyc);
    checkOutput({tag, " imem_req cycles"}, c_imem, exp_imem);
    checkOutput({tag, " ir_we pulses"}, c_irwe, n + 1);
    checkOutput({tag, " dmem_req cycles"}, c_dreq, exp_dreq);
    checkOutput({tag, " dmem_wr cycles"}, c_dwr, exp_dwr);
    checkOutput({tag, " pc_we pulses"}, c_pc, n);
    checkOutput({tag, " rf_we pulses"}, c_rf, exp_rf);
    checkOutput({tag, " retire_cnt"}, bus.retire_cnt, n % (1 << CW));
    checkOutput({tag, " err"}, bus.err, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    setFields(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.imem_done = 1'b0;
    bus.dmem_done = 1'b0;

    vecs[0] = mkVec(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 2'd0);
    vecs[1] = mkVec(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 2'd0);
    vecs[2] = mkVec(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 2'd0);
    vecs[3] = mkVec(5'b10001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'd0);
    vecs[4] = mkVec(5'b10000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0);
    vecs[5] = mkVec(5'b10000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0);
    vecs[6] = mkVec(5'b00000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 2'd0);
    vecs[7] = mkVec(5'b01111, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 2'd1);
    vecs[8] = mkVec(5'b01000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 2'd0);

    // ALU with fetch done on the third cycle, load with 4 MEM cycles, HALT.
    doReset();
    #1;
    checkOutput("reset state", bus.state, 0);
    checkOutput("reset strobes",
                {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_wr, bus.pc_we, bus.rf_we}, 0);
    checkOutput("reset status", {bus.halted, bus.err, bus.err_code}, 0);
    checkOutput("reset retire_cnt", bus.retire_cnt, 0);
    @(negedge clk);
    setFields(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetchWith(3, "alu");
    #1;
    checkOutput("alu decode state", bus.state, 2);
    @(negedge clk);
    #1;
    checkOutput("alu wb pc_we", bus.pc_we, 1);
    checkOutput("alu wb rf_we", bus.rf_we, 1);
    @(negedge clk);
    #1;
    checkOutput("alu retire_cnt", bus.retire_cnt, 1);
    setFields(5'b10001, 1'b1, 1'b1, 1'b0, 1'b0);
    fetchWith(1, "load");
    @(negedge clk);
    memWith(4, 1'b0, "load");
    #1;
    checkOutput("load wb rf_we", bus.rf_we, 1);
    @(negedge clk);
    #1;
    checkOutput("load retire_cnt", bus.retire_cnt, 2);
    setFields(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetchWith(2, "halt");
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.imem_done = (i % 2 == 0);
      bus.dmem_done = (i % 2 == 1);
      #1;
      checkOutput("halt state", bus.state, 5);
      checkOutput("halt halted", bus.halted, 1);
      checkOutput("halt strobes",
                  {bus.imem_req, bus.ir_we, bus.dmem_req, bus.pc_we, bus.rf_we}, 0);
      checkOutput("halt retire_cnt", bus.retire_cnt, 2);
      @(negedge clk);
    end
    bus.imem_done = 1'b0;
    bus.dmem_done = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Exception trap is sticky.
    doReset();
    @(negedge clk);
    setFields(5'b01010, 1'b1, 1'b0, 1'b0, 1'b1);
    fetchWith(1, "exc");
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.imem_done = 1'b1;
      #1;
      checkOutput("exc state", bus.state, 6);
      checkOutput("exc err", {bus.err, bus.err_code}, 3'b101);
      checkOutput("exc imem_req", bus.imem_req, 0);
      @(negedge clk);
    end
    bus.imem_done = 1'b0;

    // Fetch never answered: 16 request cycles, then timeout trap.
    doReset();
    @(negedge clk);
    for (int i = 0; i < TMO; i++) begin
      #1;
      checkOutput("fetch wait imem_req", bus.imem_req, 1);
      @(negedge clk);
    end
    #1;
    checkOutput("fetch timeout state", bus.state, 6);
    checkOutput("fetch timeout err_code", bus.err_code, 2);
    checkOutput("fetch timeout imem_req", bus.imem_req, 0);

    // Done on the last permitted cycle is still accepted.
    doReset();
    @(negedge clk);
    setFields(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetchWith(TMO, "late fetch");
    #1;
    checkOutput("late fetch state", bus.state, 2);
    checkOutput("late fetch err", bus.err, 0);

    // Data memory never answers.
    doReset();
    @(negedge clk);
    setFields(5'b10001, 1'b1, 1'b1, 1'b0, 1'b0);
    fetchWith(1, "mem tmo");
    @(negedge clk);
    for (int i = 0; i < TMO; i++) begin
      #1;
      checkOutput("mem wait dmem_req", bus.dmem_req, 1);
      @(negedge clk);
    end
    #1;
    checkOutput("mem timeout state", bus.state, 6);
    checkOutput("mem timeout err_code", bus.err_code, 2);

    // Asynchronous reset in the middle of a MEM wait.
    doReset();
    @(negedge clk);
    setFields(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetchWith(1, "rst alu");
    @(negedge clk);
    @(negedge clk);
    setFields(5'b10001, 1'b1, 1'b1, 1'b0, 1'b0);
    fetchWith(1, "rst load");
    @(negedge clk);
    #1;
    checkOutput("pre-reset dmem_req", bus.dmem_req, 1);
    checkOutput("pre-reset retire_cnt", bus.retire_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset dmem_req", bus.dmem_req, 0);
    checkOutput("async reset state", bus.state, 0);
    checkOutput("async reset retire_cnt", bus.retire_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_done = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post-reset state", bus.state, 1);
    checkOutput("post-reset dmem_req", bus.dmem_req, 0);
    @(negedge clk);
    bus.dmem_done = 1'b0;
    #1;
    checkOutput("post-reset still fetch", bus.state, 1);
    checkOutput("post-reset retire_cnt", bus.retire_cnt, 0);

    for (int r = 0; r < 3; r++) runRandom($urandom_range(30, 17), r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
